// File: rtl/stream_capture_buffer.sv
// Trigger-based capture of a 128-bit sample stream into a ring RAM, read out over Wishbone.
// Latency: beats stored one cycle after acceptance; Wishbone ack (with read data) one cycle after request.
// Backpressure: never applied (cap_tready tied high); optional STREAM_CAPTURE_TIMESTAMP_EN adds a trigger timestamp.
module stream_capture_buffer #(
  parameter int DEPTH_LOG2     = 9,
  parameter int POSTTRIG_RESET = 256
) (
  input  logic                  aclk,
  input  logic                  reset_i,
  input  logic [127:0]          cap_tdata,
  input  logic                  cap_tvalid,
  output logic                  cap_tready,
  input  logic                  trig_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [DEPTH_LOG2+2:0] wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  input  logic [3:0]            wb_sel_i,
  output logic                  wb_ack_o,
  output logic [31:0]           wb_dat_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int AW    = DEPTH_LOG2 + 3;

  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;
  state_t state, state_nxt;

  logic [DEPTH_LOG2-1:0] wr_ptr, trig_ptr, posttrig, post_cnt;
  logic [DEPTH_LOG2:0]   cnt_p1;
  logic [31:0]           tstamp;
  logic [95:0]           beat;
  logic [95:0]           mem [DEPTH];
  logic [95:0]           ram_q;
  logic [1:0]            pair_q;
  logic                  ram_sel_q;
  logic [31:0]           reg_q, reg_rd, ram_word;
  logic                  ack;
  logic                  wb_req, wb_wr, ram_region, ctrl_wr, ptrig_wr;
  logic                  arm, force_trig;
  logic                  wr_en, trig_hit, cnt_inc;
  logic [AW-2:0]         reg_idx;
  logic                  unused_bits;

  assign cap_tready = 1'b1;
  assign unused_bits = ^{wb_sel_i, wb_dat_i, cap_tdata};

  // Drop the 4 low padding bits of each 16-bit lane to form the 96-bit stored word.
  always_comb begin
    beat = '0;
    for (int i = 0; i < 8; i++) begin
      beat[i*12 +: 12] = cap_tdata[i*16+4 +: 12];
    end
  end

  // A new access is seen only when no ack is pending, so back-to-back accesses take 2 cycles each.
  assign wb_req     = wb_cyc_i & wb_stb_i & ~ack;
  assign wb_wr      = wb_req & wb_we_i;
  assign ram_region = wb_adr_i[AW-1];
  assign reg_idx    = wb_adr_i[AW-2:0];
  assign ctrl_wr    = wb_wr & ~ram_region & (reg_idx == (AW-1)'(0));
  assign ptrig_wr   = wb_wr & ~ram_region & (reg_idx == (AW-1)'(1));
  // ARM wins over FORCE_TRIG when both are set in one write.
  assign arm        = ctrl_wr & wb_dat_i[0];
  assign force_trig = ctrl_wr & wb_dat_i[1] & ~wb_dat_i[0];
  assign cnt_p1     = {1'b0, post_cnt} + (DEPTH_LOG2+1)'(1);

  // Capture FSM next-state and datapath strobes.
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    trig_hit  = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: ;
      ARMED: begin
        wr_en = cap_tvalid;
        if (trig_i || force_trig) begin
          state_nxt = POST;
          trig_hit  = 1'b1;
        end
      end
      POST: begin
        if (posttrig == '0) begin
          state_nxt = DONE;
        end else if (cap_tvalid) begin
          wr_en   = 1'b1;
          cnt_inc = 1'b1;
          if (cnt_p1 >= {1'b0, posttrig}) state_nxt = DONE;
        end
      end
      DONE: ;
    endcase
    if (arm) begin
      state_nxt = ARMED;
      trig_hit  = 1'b0;
    end
  end

  // State, pointers, post-trigger counter and POSTTRIG register.
  always_ff @(posedge aclk) begin
    if (reset_i) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      trig_ptr <= '0;
      post_cnt <= '0;
      posttrig <= DEPTH_LOG2'(POSTTRIG_RESET);
    end else begin
      state <= state_nxt;
      if (wr_en) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (trig_hit) trig_ptr <= wr_ptr;
      if (arm || trig_hit) post_cnt <= '0;
      else if (cnt_inc) post_cnt <= cnt_p1[DEPTH_LOG2-1:0];
      if (ptrig_wr) posttrig <= wb_dat_i[DEPTH_LOG2-1:0];
    end
  end

  // Sample RAM: one write port from the stream, one registered read port for Wishbone.
  always_ff @(posedge aclk) begin
    if (wr_en && !reset_i) mem[wr_ptr] <= beat;
    if (wb_req && ram_region) begin
      ram_q  <= mem[wb_adr_i[AW-2:2]];
      pair_q <= wb_adr_i[1:0];
    end
  end

`ifdef STREAM_CAPTURE_TIMESTAMP_EN
  logic [31:0] ts_cnt;

  // Free-running cycle counter, sampled into TSTAMP on the trigger cycle.
  always_ff @(posedge aclk) begin
    if (reset_i) begin
      ts_cnt <= '0;
      tstamp <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (trig_hit) tstamp <= ts_cnt;
    end
  end
`else
  assign tstamp = 32'd0;
`endif

  // Register read mux, captured at request time.
  always_comb begin
    reg_rd = 32'd0;
    case (reg_idx)
      (AW-1)'(0): reg_rd = {29'd0, (state == POST) || (state == DONE), state == DONE,
                            (state == ARMED) || (state == POST)};
      (AW-1)'(1): reg_rd = {{(32-DEPTH_LOG2){1'b0}}, posttrig};
      (AW-1)'(2): reg_rd = {{(32-DEPTH_LOG2){1'b0}}, trig_ptr};
      (AW-1)'(3): reg_rd = tstamp;
      default:    reg_rd = 32'd0;
    endcase
  end

  // Pick the addressed sample pair out of the RAM word, each sample left-aligned in 16 bits.
  always_comb begin
    ram_word = 32'd0;
    case (pair_q)
      2'd0: ram_word = {ram_q[23:12], 4'd0, ram_q[11:0],  4'd0};
      2'd1: ram_word = {ram_q[47:36], 4'd0, ram_q[35:24], 4'd0};
      2'd2: ram_word = {ram_q[71:60], 4'd0, ram_q[59:48], 4'd0};
      2'd3: ram_word = {ram_q[95:84], 4'd0, ram_q[83:72], 4'd0};
    endcase
  end

  // Single-cycle ack; an access in flight during reset is dropped.
  always_ff @(posedge aclk) begin
    if (reset_i) begin
      ack       <= 1'b0;
      ram_sel_q <= 1'b0;
      reg_q     <= 32'd0;
    end else begin
      ack <= wb_req;
      if (wb_req) begin
        ram_sel_q <= ram_region;
        reg_q     <= reg_rd;
      end
    end
  end

  assign wb_ack_o = ack;
  assign wb_dat_o = ack ? (ram_sel_q ? ram_word : reg_q) : 32'd0;

endmodule

// File: tb/tb_stream_capture_buffer.sv
// Directed bench for stream_capture_buffer: reads push expected data, a monitor checks each ack.
// Latency: one Wishbone access per 2 cycles; stream beats one per cycle.
// Backpressure: none expected; cap_tready must stay high.
module tb_stream_capture_buffer;
  localparam int DL = 9;
  localparam int AW = DL + 3;
  localparam logic [AW-1:0] A_CTRL  = 12'h000;
  localparam logic [AW-1:0] A_PTRIG = 12'h001;
  localparam logic [AW-1:0] A_TPTR  = 12'h002;
  localparam logic [AW-1:0] A_TSTMP = 12'h003;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic [127:0]  cap_tdata = '0;
  logic          cap_tvalid = 1'b0;
  logic          cap_tready;
  logic          trig_i = 1'b0;
  logic          wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [AW-1:0] wb_adr = '0;
  logic [31:0]   wb_dat = '0;
  logic [3:0]    wb_sel = 4'hF;
  logic          wb_ack_o;
  logic [31:0]   wb_dat_o;

  int n_vec = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  stream_capture_buffer dut (
    .aclk(clk), .reset_i(reset_i),
    .cap_tdata(cap_tdata), .cap_tvalid(cap_tvalid), .cap_tready(cap_tready),
    .trig_i(trig_i),
    .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
    .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_sel_i(wb_sel),
    .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: every read ack pops one expectation.
  always @(negedge clk) begin
    if (wb_ack_o && !wb_we) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_ack got %h with nothing pending", wb_dat_o);
      end else begin
        logic [31:0] e;
        string nm;
        e = exp_q.pop_front();
        nm = name_q.pop_front();
        if (wb_dat_o !== e) begin
          n_fail++;
          $display("FAIL %s got %h required %h", nm, wb_dat_o, e);
        end
      end
    end
  end

  function automatic logic [127:0] mk_beat(input int b, input int m);
    logic [127:0] d;
    d = '0;
    for (int i = 0; i < 8; i++) d[i*16 +: 16] = {12'(b*m + i), 4'hA};
    return d;
  endfunction

  function automatic logic [31:0] exp_word(input int b, input int m, input int p);
    return {12'(b*m + 2*p + 1), 4'h0, 12'(b*m + 2*p), 4'h0};
  endfunction

  function automatic logic [AW-1:0] ram_adr(input int b, input int p);
    return {1'b1, 9'(b), 2'(p)};
  endfunction

  task automatic check1(input string nm, input logic act, input logic req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s got %b required %b", nm, act, req);
    end
  endtask

  task automatic wb_access(input logic we, input logic [AW-1:0] adr, input logic [31:0] dat,
                           input logic [31:0] exp, input string nm);
    if (!we) begin
      exp_q.push_back(exp);
      name_q.push_back(nm);
    end
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat = dat;
    @(posedge clk); #1;
    check1({nm, "_ack"}, wb_ack_o, 1'b1);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(posedge clk); #1;
    check1({nm, "_ack_width"}, wb_ack_o, 1'b0);
  endtask

  task automatic wr(input logic [AW-1:0] adr, input logic [31:0] dat, input string nm);
    wb_access(1'b1, adr, dat, 32'd0, nm);
  endtask

  task automatic rd(input logic [AW-1:0] adr, input logic [31:0] exp, input string nm);
    wb_access(1'b0, adr, 32'd0, exp, nm);
  endtask

  task automatic stream(input int first, input int cnt, input int m, input int trig_at);
    for (int b = first; b < first + cnt; b++) begin
      cap_tdata = mk_beat(b, m);
      cap_tvalid = 1'b1;
      trig_i = (b == trig_at);
      @(posedge clk); #1;
    end
    cap_tvalid = 1'b0;
    trig_i = 1'b0;
  endtask

  // Reset for one sampled edge; optionally with a read request in flight that must be dropped.
  task automatic reset_dut(input logic with_req);
    reset_i = 1'b1;
    if (with_req) begin
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = A_CTRL;
    end
    @(posedge clk); #1;
    if (with_req) check1("ack_in_reset", wb_ack_o, 1'b0);
    reset_i = 1'b0;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(posedge clk); #1;
    if (with_req) check1("ack_after_reset", wb_ack_o, 1'b0);
  endtask

  initial begin
    @(posedge clk); #1;
    reset_dut(1'b0);

    // Reset state
    check1("tready", cap_tready, 1'b1);
    check1("ack_idle", wb_ack_o, 1'b0);
    n_vec++;
    if (wb_dat_o !== 32'd0) begin
      n_fail++;
      $display("FAIL dat_idle got %h required 0", wb_dat_o);
    end
    rd(A_CTRL,  32'd0,   "rst_ctrl");
    rd(A_PTRIG, 32'd256, "rst_posttrig");
    rd(A_TPTR,  32'd0,   "rst_trigptr");
    rd(A_TSTMP, 32'd0,   "rst_tstamp");

    // Capture with ramp data, trigger at wr_ptr=100, POSTTRIG=4
    wr(A_PTRIG, 32'd4, "cap_ptrig");
    rd(A_PTRIG, 32'd4, "cap_ptrig_rb");
    wr(A_CTRL, 32'd1, "cap_arm");
    rd(A_CTRL, 32'd1, "cap_armed");
    stream(0, 101, 8, 100);
    stream(101, 3, 8, -1);
    rd(A_CTRL, 32'd5, "cap_post3");
    stream(104, 1, 8, -1);
    rd(A_CTRL, 32'd6, "cap_done");
    stream(105, 3, 8, -1);
    rd(A_TPTR, 32'd100, "cap_trigptr");
    rd(ram_adr(100, 0), 32'h3210_3200, "cap_ram100_p0");
    rd(ram_adr(104, 3), exp_word(104, 8, 3), "cap_ram104_p3");
    rd(ram_adr(101, 1), exp_word(101, 8, 1), "cap_ram101_p1");
    rd(ram_adr(7, 2), exp_word(7, 8, 2), "cap_ram7_p2");
    rd(A_CTRL, 32'd6, "cap_done_hold");

    // Back-to-back reads with strobe held: ack every other cycle
    exp_q.push_back(32'd100); name_q.push_back("b2b_first");
    exp_q.push_back(32'd100); name_q.push_back("b2b_second");
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = A_TPTR;
    @(posedge clk); #1; check1("b2b_ack1", wb_ack_o, 1'b1);
    @(posedge clk); #1; check1("b2b_gap", wb_ack_o, 1'b0);
    @(posedge clk); #1; check1("b2b_ack2", wb_ack_o, 1'b1);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(posedge clk); #1; check1("b2b_end", wb_ack_o, 1'b0);

    // Wrap: 600 beats armed, trigger at beat 600, 4 post beats -> 605 beats written
    reset_dut(1'b0);
    wr(A_PTRIG, 32'd4, "wrap_ptrig");
    wr(A_CTRL, 32'd1, "wrap_arm");
    stream(0, 600, 3, -1);
    stream(600, 5, 3, 600);
    rd(A_CTRL, 32'd6, "wrap_done");
    rd(A_TPTR, 32'd88, "wrap_trigptr");
    rd(ram_adr(0, 0), exp_word(512, 3, 0), "wrap_ram0");
    rd(ram_adr(511, 2), exp_word(511, 3, 2), "wrap_ram511");
    rd(ram_adr(92, 1), exp_word(604, 3, 1), "wrap_ram92");
    rd(ram_adr(93, 0), exp_word(93, 3, 0), "wrap_ram93_old");
    wr(ram_adr(93, 0), 32'hFFFF_FFFF, "wrap_ram_wr_ignored");
    rd(ram_adr(93, 0), exp_word(93, 3, 0), "wrap_ram93_kept");

    // POSTTRIG=0 with FORCE_TRIG while a beat is valid: only the trigger beat lands
    wr(A_PTRIG, 32'd0, "zero_ptrig");
    rd(A_PTRIG, 32'd0, "zero_ptrig_rb");
    wr(A_CTRL, 32'd1, "zero_arm");
    cap_tdata = mk_beat(700, 3);
    cap_tvalid = 1'b1;
    wr(A_CTRL, 32'd2, "zero_force");
    rd(A_CTRL, 32'd6, "zero_done");
    cap_tvalid = 1'b0;
    rd(A_TPTR, 32'd93, "zero_trigptr");
    rd(ram_adr(93, 0), exp_word(700, 3, 0), "zero_trig_beat");
    rd(ram_adr(94, 0), exp_word(94, 3, 0), "zero_no_extra");

    // Ignored trigger in IDLE; ARM+FORCE together arms only
    reset_dut(1'b0);
    trig_i = 1'b1;
    @(posedge clk); #1;
    trig_i = 1'b0;
    rd(A_CTRL, 32'd0, "idle_trig_ctrl");
    rd(A_TPTR, 32'd0, "idle_trig_ptr");
    wr(A_CTRL, 32'd3, "armforce_wr");
    rd(A_CTRL, 32'd1, "armforce_ctrl");

    // Reset in the middle of POST, with a read in flight
    reset_dut(1'b0);
    wr(A_CTRL, 32'd1, "mid_arm");
    stream(0, 10, 8, 5);
    rd(A_CTRL, 32'd5, "mid_post");
    reset_dut(1'b1);
    rd(A_CTRL,  32'd0,   "mid_rst_ctrl");
    rd(A_PTRIG, 32'd256, "mid_rst_ptrig");
    rd(A_TPTR,  32'd0,   "mid_rst_tptr");
    wr(A_CTRL, 32'd1, "mid_rearm");
    rd(A_CTRL, 32'd1, "mid_rearm_ctrl");
    stream(0, 5, 8, -1);
    wr(A_CTRL, 32'd2, "mid_force");
    rd(A_TPTR, 32'd5, "mid_force_tptr");
    rd(A_CTRL, 32'd5, "mid_force_ctrl");

    // Trigger sampled in cycle 1000 after reset
    reset_dut(1'b0);
    wr(A_CTRL, 32'd1, "ts_arm");
    repeat (997) @(posedge clk);
    #1;
    trig_i = 1'b1;
    @(posedge clk); #1;
    trig_i = 1'b0;
    rd(A_CTRL, 32'd5, "ts_post");
`ifdef STREAM_CAPTURE_TIMESTAMP_EN
    rd(A_TSTMP, 32'd1000, "ts_value");
`else
    rd(A_TSTMP, 32'd0, "ts_value");
`endif

    @(posedge clk); #1;
    @(posedge clk); #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_reads got %0d outstanding required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/stream_capture_buffer.md
STREAM_CAPTURE_BUFFER -- requirements
Module: stream_capture_buffer

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 9, giving log2 of ring-buffer depth in 128-bit beats (512 beats, 4096 samples).
REQ-002 SHALL have parameter POSTTRIG_RESET, default 256, giving the reset value of POSTTRIG.
REQ-003 SHALL have port aclk, input, 1: the single clock; all logic, including Wishbone, is synchronous to it.
REQ-004 SHALL have port reset_i, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port cap_tdata, input, 128: eight 16-bit lanes; the sample is bits [16i+4 +: 12] and bits [16i +: 4] are ignored.
REQ-006 SHALL have port cap_tvalid, input, 1: beat valid.
REQ-007 SHALL have port cap_tready, output, 1: tied high.
REQ-008 SHALL have port trig_i, input, 1: external trigger, level-sampled every cycle.
REQ-009 SHALL have ports wb_cyc_i and wb_stb_i, input, 1 each: Wishbone cycle and strobe.
REQ-010 SHALL have port wb_we_i, input, 1: Wishbone write enable.
REQ-011 SHALL have port wb_adr_i, input, DEPTH_LOG2+3: word address.
REQ-012 SHALL have ports wb_dat_i, input, 32, and wb_sel_i, input, 4: write data and byte selects; wb_sel_i is ignored.
REQ-013 SHALL have port wb_ack_o, output, 1: Wishbone acknowledge.
REQ-014 SHALL have port wb_dat_o, output, 32: Wishbone read data.

Function
REQ-015 SHALL hold, per beat, the unpacked 96-bit word {s7..s0} (each 12 bits) in one RAM of 2^DEPTH_LOG2 entries with 1-cycle read latency.
REQ-016 SHALL use FSM states IDLE, ARMED, POST and DONE.
REQ-017 SHALL write a beat only in ARMED or POST when cap_tvalid=1: store at wr_ptr, then wr_ptr += 1 modulo 2^DEPTH_LOG2; beats in other states are accepted and discarded.
REQ-018 SHALL decode registers when wb_adr_i MSB=0: 0 CTRL, 1 POSTTRIG (DEPTH_LOG2 bits, R/W), 2 TRIG_PTR (read-only), 3 TSTAMP (read-only); other addresses read 0.
REQ-019 SHALL, on a CTRL write, treat bit0 as ARM and bit1 as FORCE_TRIG.
REQ-020 SHALL return CTRL reads as {29'b0, triggered(POST|DONE), done(DONE), armed(ARMED|POST)}.
REQ-021 SHALL move IDLE/DONE/ARMED/POST to ARMED on ARM=1; wr_ptr is not cleared.
REQ-022 SHALL ignore FORCE_TRIG in the same write when ARM=1.
REQ-023 SHALL move ARMED to POST on trig_i=1 or FORCE_TRIG=1 and latch TRIG_PTR=wr_ptr; a beat valid in that cycle is the trigger beat.
REQ-024 SHALL ignore trig_i in IDLE, POST and DONE.
REQ-025 SHALL, in POST, count beats accepted after the trigger cycle and enter DONE on the beat that makes the count equal POSTTRIG.
REQ-026 SHALL, when POSTTRIG=0, enter DONE on the cycle after the trigger.
REQ-027 SHALL map a read with wb_adr_i MSB=1 and low bits {beat[DEPTH_LOG2-1:0], pair[1:0]} to {s(2p+1),4'b0,s(2p),4'b0} of that beat.
REQ-028 SHALL return live RAM contents for reads in any state.
REQ-029 SHALL ack writes to the RAM region but otherwise ignore them.
REQ-030 SHALL assert wb_ack_o for exactly one cycle, in the cycle after cyc&stb&~ack is seen, with read data valid in the same cycle.
REQ-031 SHALL treat back-to-back accesses as each taking 2 cycles.

Reset
REQ-032 SHALL, on reset_i, set state IDLE, wr_ptr 0, TRIG_PTR 0, TSTAMP 0, POSTTRIG POSTTRIG_RESET, wb_ack_o 0 and wb_dat_o 0; RAM contents are undefined.
REQ-033 SHALL abort an in-progress capture to IDLE on reset mid-capture.
REQ-034 SHALL drop an in-flight Wishbone access on reset with no ack.

Configuration
REQ-035 SHALL, with STREAM_CAPTURE_TIMESTAMP_EN defined, run a 32-bit free-running cycle counter (wraps, cleared by reset) and latch it into TSTAMP at the trigger cycle.
REQ-036 SHALL, without STREAM_CAPTURE_TIMESTAMP_EN, implement no counter and read TSTAMP as 0.

Verification
REQ-037 SHALL verify capture: POSTTRIG=4, ARM, stream ramp beats (sample n = n mod 4096), trig_i at wr_ptr=100 -> DONE after beat 104 written, TRIG_PTR=100, RAM address {100,pair 0} reads {s801,4'b0,s800,4'b0}.
REQ-038 SHALL verify a zero post-trigger count: POSTTRIG=0, FORCE_TRIG with cap_tvalid=1 -> only the trigger beat is written and CTRL reads 0b110 two cycles later.
REQ-039 SHALL verify wrap: ARMED for 600 beats, then trigger -> wr_ptr wraps 511->0 and beat 512 overwrites address 0.
REQ-040 SHALL verify simultaneous and ignored events: CTRL write 0b11 from IDLE -> ARMED, not triggered; trig_i pulse in IDLE -> no state change.
REQ-041 SHALL verify reset mid-POST: reset_i during POST -> IDLE, CTRL reads 0, POSTTRIG reads 256, a subsequent ARM works.
REQ-042 SHALL verify the timestamp: with the macro, trigger at cycle 1000 after reset -> TSTAMP reads 1000 (±1 per the counter's reset convention); without it -> 0.
